fnd_scan_controller: RTL

Time-multiplexed driver for a common-anode seven-segment (FND) display of parametrised digit count. Takes a packed BCD word plus per-digit decimal-point and blink masks, latches them once per frame, and scans digits one at a time with a configurable dwell and an anti-ghosting blank gap. Adds leading-zero suppression and blinking. Sits between the calculator datapath and the board's FND pins, replacing the external digit-select counter plus combinational decoder arrangement.

---
 rtl/fnd_pkg.sv | 29 ++
 rtl/fnd_font_rom.sv | 28 ++
 rtl/fnd_scan_controller.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fnd_pkg.sv
// fnd_pkg: shared definitions for the FND scan controller.
//   - Active-low 7-segment patterns {g,f,e,d,c,b,a} for BCD 0..9, dash and blank.
//   - Scan-slot state enum (blank gap vs. digit on).
//   - cnt_width(): register width needed to hold a counter running 0..n-1.
package fnd_pkg;

  localparam logic [6:0] FONT_0     = 7'h40;
  localparam logic [6:0] FONT_1     = 7'h79;
  localparam logic [6:0] FONT_2     = 7'h24;
  localparam logic [6:0] FONT_3     = 7'h30;
  localparam logic [6:0] FONT_4     = 7'h19;
  localparam logic [6:0] FONT_5     = 7'h12;
  localparam logic [6:0] FONT_6     = 7'h02;
  localparam logic [6:0] FONT_7     = 7'h78;
  localparam logic [6:0] FONT_8     = 7'h00;
  localparam logic [6:0] FONT_9     = 7'h10;
  localparam logic [6:0] FONT_DASH  = 7'h3F;
  localparam logic [6:0] FONT_BLANK = 7'h7F;

  typedef enum logic {
    SCAN_BLANK = 1'b0,
    SCAN_ON    = 1'b1
  } scan_state_t;

  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fnd_font_rom.sv
// fnd_font_rom: combinational BCD to active-low 7-segment decoder.
//   bcd : in  4  code 0..9 digits, 10 dash, 11..15 blank
//   seg : out 7  segments {g,f,e,d,c,b,a}, active-low
module fnd_font_rom
  import fnd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = FONT_0;
      4'd1:    seg = FONT_1;
      4'd2:    seg = FONT_2;
      4'd3:    seg = FONT_3;
      4'd4:    seg = FONT_4;
      4'd5:    seg = FONT_5;
      4'd6:    seg = FONT_6;
      4'd7:    seg = FONT_7;
      4'd8:    seg = FONT_8;
      4'd9:    seg = FONT_9;
      4'd10:   seg = FONT_DASH;
      default: seg = FONT_BLANK;
    endcase
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: time-multiplexed common-anode FND driver.
//   i_clk         in   1             system clock
//   i_reset       in   1             asynchronous active-high reset
//   i_en          in   1             display enable (low = synchronous restart)
//   i_value       in   4*NUM_DIGITS  BCD digits, nibble k drives digit k (0 = rightmost)
//   i_dp          in   NUM_DIGITS    decimal point per digit, 1 = lit
//   i_blink       in   NUM_DIGITS    per-digit blink enable
//   i_lz_blank    in   1             leading-zero suppression enable
//   o_digit       out  NUM_DIGITS    digit select, active-low, one-cold or all ones
//   o_fndfont     out  8             segments {dp,g,f,e,d,c,b,a}, active-low
//   o_frame_start out  1             pulse on the cycle the shadow registers load
// Each digit owns a slot of CLK_HZ/SCAN_HZ cycles; the first BLANK_CYCLES of
// every slot drive everything off so the previous digit cannot ghost.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_HZ     = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_en,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_blink,
  input  logic                    i_lz_blank,
  output logic [NUM_DIGITS-1:0]   o_digit,
  output logic [7:0]              o_fndfont,
  output logic                    o_frame_start
);

  localparam int SLOT   = CLK_HZ / SCAN_HZ;
  localparam int HALF   = CLK_HZ / (2 * BLINK_HZ);
  localparam int SLOT_W = cnt_width(SLOT);
  localparam int IDX_W  = cnt_width(NUM_DIGITS);
  localparam int PH_W   = cnt_width(HALF);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT - 1);
  localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(HALF - 1);

  logic [SLOT_W-1:0]       slot_cnt;
  logic [IDX_W-1:0]        idx;
  logic [PH_W-1:0]         ph_cnt;
  logic                    phase;
  logic                    frame_load;

  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blink;
  logic                    sh_lz;

  logic [4*NUM_DIGITS-1:0] cur_value;
  logic [NUM_DIGITS-1:0]   cur_dp;
  logic [NUM_DIGITS-1:0]   cur_blink;
  logic                    cur_lz;

  scan_state_t             state;
  logic [3:0]              cur_nibble;
  logic                    cur_dp_bit;
  logic                    cur_blink_bit;
  logic                    lz_hit;
  logic                    all_zero;
  logic [NUM_DIGITS-1:0]   lz_zero;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    hide;
  logic [6:0]              seg;

  // Shadow load happens on slot 0 of digit 0, which is also the first cycle
  // after reset release or enable rise since the counters restart at zero.
  assign frame_load = i_en && (slot_cnt == '0) && (idx == '0);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      slot_cnt <= '0;
      idx      <= '0;
      ph_cnt   <= '0;
      phase    <= 1'b0;
    end else if (!i_en) begin
      slot_cnt <= '0;
      idx      <= '0;
      ph_cnt   <= '0;
      phase    <= 1'b0;
    end else begin
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
      // Blink phase runs independently of the frame.
      if (ph_cnt == PH_LAST) begin
        ph_cnt <= '0;
        phase  <= ~phase;
      end else begin
        ph_cnt <= ph_cnt + 1'b1;
      end
    end
  end

  // NOTE: shadow registers are plain flops with a defined reset value, so a
  // display enabled before the first load never shows stale garbage.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sh_value <= '0;
      sh_dp    <= '0;
      sh_blink <= '0;
      sh_lz    <= 1'b0;
    end else if (frame_load) begin
      sh_value <= i_value;
      sh_dp    <= i_dp;
      sh_blink <= i_blink;
      sh_lz    <= i_lz_blank;
    end
  end

  // On the load cycle itself, look through to the inputs so the first slot
  // never decodes the previous frame's contents.
  assign cur_value = frame_load ? i_value    : sh_value;
  assign cur_dp    = frame_load ? i_dp       : sh_dp;
  assign cur_blink = frame_load ? i_blink    : sh_blink;
  assign cur_lz    = frame_load ? i_lz_blank : sh_lz;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state         = (slot_cnt < BLANK_END) ? SCAN_BLANK : SCAN_ON;
    cur_nibble    = '0;
    cur_dp_bit    = 1'b0;
    cur_blink_bit = 1'b0;
    lz_hit        = 1'b0;
    digit_sel     = '1;
    all_zero      = 1'b1;
    lz_zero       = '0;
    // lz_zero[k]: nibbles k..top are all zero; digit 0 is never a candidate.
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      all_zero   = all_zero & (cur_value[4*k +: 4] == 4'd0);
      lz_zero[k] = all_zero;
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nibble    = cur_value[4*k +: 4];
        cur_dp_bit    = cur_dp[k];
        cur_blink_bit = cur_blink[k];
        lz_hit        = lz_zero[k];
        digit_sel[k]  = 1'b0;
      end
    end
    hide = (cur_lz & lz_hit) | (phase & cur_blink_bit);
  end

  fnd_font_rom u_font_rom (
    .bcd (cur_nibble),
    .seg (seg)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_digit       <= '1;
      o_fndfont     <= 8'hFF;
      o_frame_start <= 1'b0;
    end else if (!i_en) begin
      o_digit       <= '1;
      o_fndfont     <= 8'hFF;
      o_frame_start <= 1'b0;
    end else begin
      o_frame_start <= frame_load;
      if (state == SCAN_ON) begin
        // Suppressed digits keep their select asserted but show nothing.
        o_digit   <= digit_sel;
        o_fndfont <= hide ? 8'hFF : {~cur_dp_bit, seg};
      end else begin
        o_digit   <= '1;
        o_fndfont <= 8'hFF;
      end
    end
  end

endmodule
